// File: rtl/vital_alarm_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : vital_alarm_monitor
//  Brief    : Multi-channel vital-sign alarm engine with persistence filtering,
//             hysteresis, sticky alarms with acknowledge and first-alarm capture.
//  Revision : 1.0  initial release
// ============================================================================
module vital_alarm_monitor #(
   parameter  int CH      = 4,
   parameter  int W       = 8,
   parameter  int PERSIST = 4,
   parameter  int CLEAR   = 4,
   parameter  int HYST    = 2,
   localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sample_valid,
   input  logic [CHW-1:0] sample_ch,
   input  logic [W-1:0]   sample_data,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [W-1:0]   cfg_lo,
   input  logic [W-1:0]   cfg_hi,
   input  logic [CH-1:0]  ack,
   output logic [CH-1:0]  alarm,
   output logic [CH-1:0]  alarm_latched,
   output logic           alarm_any,
   output logic [CH-1:0]  level_high,
   output logic [CHW-1:0] first_ch,
   output logic           first_valid
);

   localparam int c_cnt_max = (PERSIST > CLEAR) ? PERSIST : CLEAR;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam int c_w1      = W + 1;

   localparam logic [c_cnt_w-1:0] c_persist = c_cnt_w'(PERSIST);
   localparam logic [c_cnt_w-1:0] c_clear   = c_cnt_w'(CLEAR);
   localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
   localparam logic [W:0]         c_hyst    = c_w1'(HYST);
   localparam logic [W:0]         c_sat     = {1'b0, {W{1'b1}}};

   // Bit 1 of the encoding is the live alarm flag (ALARM or RECOVER).
   localparam logic [1:0] c_normal  = 2'b00;
   localparam logic [1:0] c_pending = 2'b01;
   localparam logic [1:0] c_alarm   = 2'b10;
   localparam logic [1:0] c_recover = 2'b11;

   logic [CH-1:0]  w_entry;
   logic [CH-1:0]  w_latched_nx;
   logic [CH-1:0]  w_alarm_v;
   logic [CH-1:0]  w_level_v;
   logic [CHW-1:0] w_low_idx;
   logic [CH-1:0]  r_latched;
   logic           r_alarm_any;
   logic [CHW-1:0] r_first_ch;
   logic           r_first_valid;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      localparam logic [CHW-1:0] c_idx = CHW'(i);

      logic [W-1:0]       r_lo;
      logic [W-1:0]       r_hi;
      logic [1:0]         r_state;
      logic [1:0]         w_state_nx;
      logic [c_cnt_w-1:0] r_cnt;
      logic [c_cnt_w-1:0] w_cnt_nx;
      logic [c_cnt_w-1:0] w_cnt_inc;
      logic               r_level;
      logic               w_cfg_hit;
      logic               w_smp_hit;
      logic               w_abnormal;
      logic               w_recovered;
      logic               w_enter;
      logic [W:0]         w_data_x;
      logic [W:0]         w_lo_sum;
      logic [W:0]         w_lo_h;
      logic [W:0]         w_hi_h;

      // A configuration write on the same channel swallows the sample.
      assign w_cfg_hit  = cfg_we && (cfg_ch == c_idx);
      assign w_smp_hit  = sample_valid && (sample_ch == c_idx) && !w_cfg_hit;
      assign w_abnormal = (sample_data < r_lo) || (sample_data > r_hi);

      // Recovery band is shrunk by HYST on both sides, saturating at the rails.
      assign w_data_x    = {1'b0, sample_data};
      assign w_lo_sum    = {1'b0, r_lo} + c_hyst;
      assign w_lo_h      = (w_lo_sum > c_sat) ? c_sat : w_lo_sum;
      assign w_hi_h      = ({1'b0, r_hi} < c_hyst) ? '0 : ({1'b0, r_hi} - c_hyst);
      assign w_recovered = (w_data_x >= w_lo_h) && (w_data_x <= w_hi_h);
      assign w_cnt_inc   = r_cnt + c_one;

      always_comb begin
         w_state_nx = r_state;
         w_cnt_nx   = r_cnt;
         w_enter    = 1'b0;
         if (w_smp_hit) begin
            case (r_state)
               c_normal: begin
                  if (w_abnormal) begin
                     if (PERSIST == 1) begin
                        w_state_nx = c_alarm;
                        w_cnt_nx   = '0;
                        w_enter    = 1'b1;
                     end else begin
                        w_state_nx = c_pending;
                        w_cnt_nx   = c_one;
                     end
                  end
               end
               c_pending: begin
                  if (!w_abnormal) begin
                     w_state_nx = c_normal;
                     w_cnt_nx   = '0;
                  end else if (w_cnt_inc == c_persist) begin
                     w_state_nx = c_alarm;
                     w_cnt_nx   = '0;
                     w_enter    = 1'b1;
                  end else begin
                     w_cnt_nx   = w_cnt_inc;
                  end
               end
               c_alarm: begin
                  if (w_recovered) begin
                     if (CLEAR == 1) begin
                        w_state_nx = c_normal;
                        w_cnt_nx   = '0;
                     end else begin
                        w_state_nx = c_recover;
                        w_cnt_nx   = c_one;
                     end
                  end
               end
               c_recover: begin
                  if (!w_recovered) begin
                     w_state_nx = c_alarm;
                     w_cnt_nx   = '0;
                  end else if (w_cnt_inc == c_clear) begin
                     w_state_nx = c_normal;
                     w_cnt_nx   = '0;
                  end else begin
                     w_cnt_nx   = w_cnt_inc;
                  end
               end
               default: begin
                  w_state_nx = c_normal;
                  w_cnt_nx   = '0;
               end
            endcase
         end
         if (w_cfg_hit) begin
            w_state_nx = c_normal;
            w_cnt_nx   = '0;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_lo    <= '0;
            r_hi    <= '1;
            r_state <= c_normal;
            r_cnt   <= '0;
            r_level <= 1'b0;
         end else begin
            if (w_cfg_hit) begin
               r_lo <= cfg_lo;
               r_hi <= cfg_hi;
            end
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_enter) begin
               r_level <= (sample_data > r_hi);
            end
         end
      end

      assign w_entry[i]   = w_enter;
      assign w_alarm_v[i] = r_state[1];
      assign w_level_v[i] = r_level;
      // Ack only takes effect while not alarmed; a fresh entry always wins.
      assign w_latched_nx[i] = w_enter | (r_latched[i] & ~(ack[i] & ~r_state[1]));
   end

   always_comb begin
      w_low_idx = '0;
      for (int k = CH - 1; k >= 0; k--) begin
         if (w_entry[k]) begin
            w_low_idx = CHW'(k);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_latched     <= '0;
         r_alarm_any   <= 1'b0;
         r_first_ch    <= '0;
         r_first_valid <= 1'b0;
      end else begin
         r_latched   <= w_latched_nx;
         r_alarm_any <= |w_latched_nx;
         if (!r_first_valid && (|w_entry)) begin
            r_first_ch    <= w_low_idx;
            r_first_valid <= 1'b1;
         end else if (w_latched_nx == '0) begin
            r_first_ch    <= '0;
            r_first_valid <= 1'b0;
         end
      end
   end

   assign alarm         = w_alarm_v;
   assign alarm_latched = r_latched;
   assign alarm_any     = r_alarm_any;
   assign level_high    = w_level_v;
   assign first_ch      = r_first_ch;
   assign first_valid   = r_first_valid;

endmodule
`default_nettype wire

// File: doc/vital_alarm_monitor.md
# vital_alarm_monitor

Parametrised multi-channel vital-sign alarm engine for the patient monitor. Accepts a time-multiplexed stream of samples (pulse count, temperature, SpO2, …) tagged by channel. Checks each sample against per-channel programmable low/high limits, with persistence filtering and hysteresis, and raises per-channel alarms. Alarms are latched until acknowledged, and the first channel to alarm is recorded. It replaces the fixed-threshold, single-sample monitors and feeds the caregiver alert/display logic.

## Interface
- CH, 4, number of monitored channels (1–16)
- W, 8, sample and threshold width in bits
- PERSIST, 4, consecutive abnormal samples on a channel needed to raise its alarm (≥1)
- CLEAR, 4, consecutive recovered samples on a channel needed to drop its alarm (≥1)
- HYST, 2, hysteresis margin applied to both limits while a channel is alarmed
- CHW (localparam), max(1, clog2(CH)), channel index width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- sample_valid  in  1  sample_ch/sample_data valid this cycle
- sample_ch  in  CHW  channel index of sample
- sample_data  in  W  unsigned sample value
- cfg_we  in  1  threshold write strobe
- cfg_ch  in  CHW  channel to configure
- cfg_lo  in  W  low limit; values below it are abnormal
- cfg_hi  in  W  high limit; values above it are abnormal
- ack  in  CH  per-channel acknowledge of latched alarm
- alarm  out  CH  live per-channel alarm (state ALARM or RECOVER)
- alarm_latched  out  CH  sticky alarm, cleared by ack
- alarm_any  out  1  OR of alarm_latched
- level_high  out  CH  for alarmed channels: 1 if the triggering excursion was above hi, 0 if below lo
- first_ch  out  CHW  first channel to enter ALARM since latches were last all clear
- first_valid  out  1  first_ch is meaningful

## Operation
- Reset values: all outputs 0. Per channel: lo=0, hi=2^W−1 (never abnormal), state NORMAL, counters 0.
- Per-channel FSM with states NORMAL, PENDING, ALARM, RECOVER, each with a shared counter cnt:
  - NORMAL: an abnormal sample (data<lo or data>hi) → PENDING, cnt=1. If PERSIST==1, go directly to ALARM instead.
  - PENDING: an abnormal sample increments cnt; when cnt reaches PERSIST → ALARM. A normal sample → NORMAL, cnt=0.
  - ALARM: a recovered sample (data ≥ lo+HYST and data ≤ hi−HYST) → RECOVER, cnt=1. If CLEAR==1, go directly to NORMAL instead.
  - RECOVER: a recovered sample increments cnt; when cnt reaches CLEAR → NORMAL. Any non-recovered sample → ALARM, cnt=0.
- Hysteresis arithmetic is done in W+1 bits:
  - lo+HYST saturates at 2^W−1.
  - hi−HYST saturates at 0.
  - If lo+HYST > hi−HYST, the channel can never recover until it is reconfigured.
- Only a sample_valid sample whose sample_ch matches the channel advances that channel's FSM. Samples on other channels neither advance nor break a streak.
- level_high[i] is captured on entry to ALARM: 1 if data>hi, else 0. It holds until the next ALARM entry.
- alarm_latched[i] sets on entry to ALARM. It clears on ack[i] only when the channel is in NORMAL or PENDING. An ack while in ALARM/RECOVER is ignored and not remembered.
- first_ch/first_valid:
  - When first_valid=0 and one or more channels enter ALARM in a cycle, capture the lowest such index and set first_valid.
  - Both clear when alarm_latched becomes all-zero. If a new entry occurs in the same cycle, the new capture wins.
- Configuration:
  - cfg_we writes lo/hi for cfg_ch and forces that channel to NORMAL with cnt=0, so its alarm drops.
  - alarm_latched, level_high and first_ch are unaffected by a configuration write.
  - lo>hi is legal: every sample is abnormal.
- Simultaneous cfg_we and sample_valid on the same channel: the config is applied and the sample is discarded. On different channels, both are applied.
- sample_ch or cfg_ch ≥ CH: the operation is ignored.
- reset asserted mid-operation: immediate return to reset values, including thresholds.

## Timing
- All outputs are registered; there is no combinational input→output path.
- alarm[i] and alarm_latched[i] rise on the clock edge that samples the PERSIST-th consecutive abnormal sample, i.e. visible 1 cycle after that sample is presented.
- alarm[i] falls on the edge sampling the CLEAR-th consecutive recovered sample.
- alarm_any follows alarm_latched with no additional latency (a registered OR, updated on the same edge).
- ack is a one-cycle strobe; alarm_latched clears on the edge where ack is sampled.
- A new sample may be accepted on every clock; there is no backpressure.
- Threshold writes take effect for samples presented on the cycle after cfg_we.

## Test plan
- Reset, then ch0 lo=60 hi=100, PERSIST=4, HYST=2: feed ch0 samples 120,120,120 → alarm[0]=0; 4th 120 → alarm[0]=1, level_high[0]=1, first_ch=0, first_valid=1, alarm_any=1.
- Streak break and interleave: ch1 lo=36 hi=38, samples ch1 30, ch2 50, ch1 30, ch1 37, ch1 30 ×3 → no alarm until the 4th consecutive ch1 abnormal. Interleaved ch2 samples must not reset the ch1 count.
- Hysteresis: ch0 alarmed with hi=100. Samples 99 ×4 → stays ALARM (99 > 98). Then 98 ×4 → alarm[0]=0 on the 4th. A 99 inside RECOVER returns the channel to ALARM.
- Ack rules: ack[0] while alarm[0]=1 → latched stays 1. After recovery, ack[0] → latched 0, alarm_any 0, first_valid 0.
- Simultaneous entry and cfg collision: ch1 and ch3 reach PERSIST in the same cycle → first_ch=1. cfg_we on ch3 with a sample on ch3 in the same cycle → the sample is dropped, alarm[3]=0, alarm_latched[3]=1.
- Async reset asserted mid-PENDING and mid-ALARM → all outputs 0 immediately; thresholds return to 0/255 and a sample of 255 does not alarm.
